// File: rtl/mem_pkg.sv
// Shared encodings for the load/store sequencer: funct3 codes, memory
// enable encodings, FSM state codes and access-size decode.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] REN_IDLE = 4'b0000;
    localparam logic [3:0] REN_LW   = 4'b1000;
    localparam logic [3:0] REN_LH   = 4'b0010;
    localparam logic [3:0] REN_LHU  = 4'b1010;
    localparam logic [3:0] REN_LB   = 4'b0001;
    localparam logic [3:0] REN_LBU  = 4'b1001;

    localparam logic [3:0] WEN_NONE = 4'b0000;
    localparam logic [3:0] WEN_SW   = 4'b1000;
    localparam logic [3:0] WEN_SH   = 4'b0010;
    localparam logic [3:0] WEN_SB   = 4'b0001;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SPLIT  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Access size in bytes; 0 marks an illegal funct3.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: size_of = 3'd1;
            F3_H, F3_HU: size_of = 3'd2;
            F3_W:        size_of = 3'd4;
            default:     size_of = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] ren_of(input logic [2:0] f3);
        case (f3)
            F3_B:    ren_of = REN_LB;
            F3_BU:   ren_of = REN_LBU;
            F3_H:    ren_of = REN_LH;
            F3_HU:   ren_of = REN_LHU;
            F3_W:    ren_of = REN_LW;
            default: ren_of = REN_IDLE;
        endcase
    endfunction

    function automatic logic [3:0] wen_of(input logic [2:0] f3);
        case (f3)
            F3_B:    wen_of = WEN_SB;
            F3_H:    wen_of = WEN_SH;
            F3_W:    wen_of = WEN_SW;
            default: wen_of = WEN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian byte buffer according
// to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] i_buf,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:  o_data = {{24{i_buf[7]}}, i_buf[7:0]};
            F3_BU: o_data = {24'h0, i_buf[7:0]};
            F3_H:  o_data = {{16{i_buf[15]}}, i_buf[15:0]};
            F3_HU: o_data = {16'h0, i_buf[15:0]};
            F3_W:  o_data = i_buf;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the byte-addressed data memory: aligned
// accesses take one memory cycle, misaligned ones are split into byte cycles.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [3:0]        mem_rEN,
    output logic [3:0]        mem_wEN,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    // Handshakes: a request transfers on the edge where req_valid && req_ready;
    // a response transfers on the edge where resp_valid && resp_ready.
    logic [1:0]        r_state;
    logic              r_store;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_k;
    logic [31:0]       r_buf;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic [2:0]        w_size;
    logic [ADDR_W:0]   w_end;
    logic              w_fault;
    logic              w_aligned;
    logic              w_last;
    logic [31:0]       w_buf_merged;
    logic [31:0]       w_ext;

    assign w_size = size_of(req_funct3);
    // One extra bit so addr+N-1 cannot wrap below MEM_BYTES.
    assign w_end  = {1'b0, req_addr} + (ADDR_W+1)'(w_size) - (ADDR_W+1)'(1);
    assign w_fault = (w_size == 3'd0) || (req_store && req_funct3[2])
                  || (w_end >= (ADDR_W+1)'(MEM_BYTES));
    assign w_aligned = (w_size == 3'd4) ? (req_addr[1:0] == 2'b00) :
                       (w_size == 3'd2) ? !req_addr[0] : 1'b1;
    assign w_last = ({1'b0, r_k} == (size_of(r_funct3) - 3'd1));

    always_comb begin
        w_buf_merged = r_buf;
        w_buf_merged[{r_k, 3'b000} +: 8] = mem_rdata[7:0];
    end

    load_extend u_load_extend (
        .i_buf    (w_buf_merged),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    always_comb begin
        mem_rEN   = REN_IDLE;
        mem_wEN   = WEN_NONE;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_ACCESS: begin
                mem_addr = r_addr;
                if (r_store) begin
                    mem_wEN   = wen_of(r_funct3);
                    mem_wdata = r_wdata;
                end else begin
                    mem_rEN = ren_of(r_funct3);
                end
            end
            ST_SPLIT: begin
                mem_addr = r_addr + ADDR_W'(r_k);
                if (r_store) begin
                    mem_wEN   = WEN_SB;
                    mem_wdata = {24'h0, r_wdata[{r_k, 3'b000} +: 8]};
                end else begin
                    mem_rEN = REN_LBU;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= ST_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_k      <= '0;
            r_buf    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_k      <= '0;
                        r_buf    <= '0;
                        r_rdata  <= '0;
                        r_err    <= w_fault;
                        if (w_fault)        r_state <= ST_RESP;
                        else if (w_aligned) r_state <= ST_ACCESS;
                        else                r_state <= ST_SPLIT;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_store ? 32'h0 : mem_rdata;
                    r_state <= ST_RESP;
                end
                ST_SPLIT: begin
                    if (!r_store) r_buf <= w_buf_merged;
                    if (w_last) begin
                        r_rdata <= r_store ? 32'h0 : w_ext;
                        r_state <= ST_RESP;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
